// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: opcode encoding, FSM states and op-decode helpers.
package mem_stage_pkg;

    localparam int unsigned OpCodeLen = 5;

    localparam logic [31:0] Zero = 32'h0000_0000;

    typedef enum logic [OpCodeLen-1:0] {
        OpNop = 5'd0,
        OpAdd = 5'd1,
        OpSub = 5'd2,
        OpAnd = 5'd3,
        OpOr  = 5'd4,
        OpXor = 5'd5,
        OpLb  = 5'd8,
        OpLh  = 5'd9,
        OpLw  = 5'd10,
        OpLbu = 5'd11,
        OpLhu = 5'd12,
        OpSb  = 5'd16,
        OpSh  = 5'd17,
        OpSw  = 5'd18
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDrain  = 2'd2,
        StDone   = 2'd3
    } state_e;

    function automatic logic is_load(logic [OpCodeLen-1:0] op);
        case (op)
            OpLb, OpLh, OpLw, OpLbu, OpLhu: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(logic [OpCodeLen-1:0] op);
        case (op)
            OpSb, OpSh, OpSw: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // Number of bytes moved by a load/store; 0 for non-memory ops.
    function automatic logic [2:0] byte_count(logic [OpCodeLen-1:0] op);
        case (op)
            OpLb, OpLbu, OpSb: return 3'd1;
            OpLh, OpLhu, OpSh: return 3'd2;
            OpLw, OpSw:        return 3'd4;
            default:           return 3'd0;
        endcase
    endfunction

    function automatic logic is_misaligned(logic [OpCodeLen-1:0] op, logic [1:0] addr_lo);
        logic [2:0] n;
        n = byte_count(op);
        return ((n == 3'd2) && addr_lo[0]) || ((n == 3'd4) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide RAM port shared with IF through an arbiter; master side is the MEM stage.
interface mem_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic              mem_wr;
    logic              mem_req;
    logic              mem_gnt;
    logic [7:0]        mem_din;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        output mem_req,
        input  mem_gnt,
        input  mem_din
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        input  mem_req,
        output mem_gnt,
        output mem_din
    );
endinterface

// File: rtl/mem_stage_load_ext.sv
// Turns the assembled little-endian load buffer into the 32-bit register value.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [OpCodeLen-1:0] op,
    input  logic [31:0]          load_data,
    output logic [31:0]          result
);

    // Sign/zero extension selected by the load opcode
    always_comb begin
        result = load_data;
        case (op)
            OpLb:    result = {{24{load_data[7]}}, load_data[7:0]};
            OpLbu:   result = {24'h0, load_data[7:0]};
            OpLh:    result = {{16{load_data[15]}}, load_data[15:0]};
            OpLhu:   result = {16'h0, load_data[15:0]};
            default: result = load_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-serial loads/stores over the shared RAM port, stalling the pipe while busy.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned half/word accesses are rejected
// with a one-cycle misalign_o flag instead of being performed.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OpCodeLen-1:0] aluop_i,
    input  logic [31:0]          rd_data_i,
    input  logic [4:0]           rd_addr_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic                 rd_enable_i,
    mem_stage_if.master          mem,
    output logic [31:0]          rd_data_o,
    output logic [4:0]           rd_addr_o,
    output logic                 rd_enable_o,
    output logic                 stall_req_o,
    output logic                 misalign_o
);

    // The capture schedule below assumes read data arrives exactly one cycle after its address
    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("mem_stage: only RD_LAT = 1 is supported");
    end

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] load_buf_q, load_buf_d;
    logic        mis_q, mis_d;

    logic        load_op, store_op, mem_op, misaligned;
    logic [2:0]  nbytes;
    logic [1:0]  cap_idx;
    logic        issue;
    logic [1:0]  issue_idx;
    logic [31:0] load_result;

    assign load_op  = is_load(aluop_i);
    assign store_op = is_store(aluop_i);
    assign mem_op   = load_op | store_op;
    assign nbytes   = byte_count(aluop_i);
    // Byte issued in the previous cycle lands now; cnt wraps 4 -> 0 which maps to lane 3
    assign cap_idx  = cnt_q[1:0] - 2'd1;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    mem_stage_load_ext u_load_ext (
        .op        (aluop_i),
        .load_data (load_buf_q),
        .result    (load_result)
    );

    // State, byte counter, load buffer and misalign flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            load_buf_q <= Zero;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_buf_q <= load_buf_d;
            mis_q      <= mis_d;
        end
    end

    // Next-state, RAM port drive and MEM/WB outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_buf_d   = load_buf_q;
        mis_d        = mis_q;
        issue        = 1'b0;
        issue_idx    = 2'd0;
        mem.mem_a    = '0;
        mem.mem_dout = 8'h00;
        mem.mem_wr   = 1'b0;
        mem.mem_req  = 1'b0;
        stall_req_o  = 1'b0;
        rd_data_o    = Zero;
        rd_addr_o    = 5'd0;
        rd_enable_o  = 1'b0;
        misalign_o   = 1'b0;

        case (state_q)
            StIdle: begin
                if (!mem_op) begin
                    rd_data_o   = rd_data_i;
                    rd_addr_o   = rd_addr_i;
                    rd_enable_o = rd_enable_i;
                end else if (misaligned) begin
                    stall_req_o = 1'b1;
                    mis_d       = 1'b1;
                    state_d     = StDone;
                end else begin
                    stall_req_o = 1'b1;
                    mem.mem_req = 1'b1;
                    if (mem.mem_gnt) begin
                        issue      = 1'b1;
                        cnt_d      = 3'd1;
                        load_buf_d = Zero;
                        if (nbytes == 3'd1) begin
                            state_d = load_op ? StDrain : StDone;
                        end else begin
                            state_d = StAccess;
                        end
                    end
                end
            end
            StAccess: begin
                stall_req_o = 1'b1;
                mem.mem_req = 1'b1;
                issue       = 1'b1;
                issue_idx   = cnt_q[1:0];
                if (load_op) begin
                    load_buf_d[{cap_idx, 3'b000} +: 8] = mem.mem_din;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == nbytes - 3'd1) begin
                    state_d = load_op ? StDrain : StDone;
                end
            end
            StDrain: begin
                stall_req_o = 1'b1;
                mem.mem_req = 1'b1;
                load_buf_d[{cap_idx, 3'b000} +: 8] = mem.mem_din;
                state_d = StDone;
            end
            StDone: begin
                rd_addr_o = rd_addr_i;
                if (mis_q) begin
                    misalign_o = 1'b1;
                end else if (load_op) begin
                    rd_data_o   = load_result;
                    rd_enable_o = rd_enable_i;
                end
                mis_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            mem.mem_a = mem_addr_i + ADDR_W'(issue_idx);
            if (store_op) begin
                mem.mem_wr   = 1'b1;
                mem.mem_dout = rd_data_i[{issue_idx, 3'b000} +: 8];
            end
        end

        // Outputs are quiet for as long as reset is held, including the passthrough path
        if (rst) begin
            mem.mem_a    = '0;
            mem.mem_dout = 8'h00;
            mem.mem_wr   = 1'b0;
            mem.mem_req  = 1'b0;
            stall_req_o  = 1'b0;
            rd_data_o    = Zero;
            rd_addr_o    = 5'd0;
            rd_enable_o  = 1'b0;
            misalign_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops against a byte-array model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  aluop;
    logic [31:0] rd_data_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] mem_addr;
    logic        rd_enable_in;
    logic [31:0] rd_data_out;
    logic [4:0]  rd_addr_out;
    logic        rd_enable_out;
    logic        stall_req;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram     [4096];
    logic [7:0] ref_ram [4096];

    mem_stage_if #(.ADDR_W(32)) bus ();

    mem_stage #(.ADDR_W(32), .RD_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop),
        .rd_data_i   (rd_data_in),
        .rd_addr_i   (rd_addr_in),
        .mem_addr_i  (mem_addr),
        .rd_enable_i (rd_enable_in),
        .mem         (bus.master),
        .rd_data_o   (rd_data_out),
        .rd_addr_o   (rd_addr_out),
        .rd_enable_o (rd_enable_out),
        .stall_req_o (stall_req),
        .misalign_o  (misalign)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency; 4 KiB window so address wrap folds naturally
    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    // Arbiter protocol: once granted, the grant stays up until the stage stops stalling
    gnt_held: assert property (@(posedge clk) disable iff (rst)
        (bus.mem_gnt && stall_req) |=> (bus.mem_gnt || !stall_req))
        else $error("FAIL gnt_held: grant dropped during an access");

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ref_nbytes(op_e op);
        case (op)
            OpLb, OpLbu, OpSb: return 1;
            OpLh, OpLhu, OpSh: return 2;
            OpLw, OpSw:        return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit ref_is_load(op_e op);
        return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
    endfunction

    function automatic bit ref_misaligned(op_e op, logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        int n;
        n = ref_nbytes(op);
        return (n == 2 && (addr % 2) != 0) || (n == 4 && (addr % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(op_e op, logic [31:0] addr);
        longint raw;
        longint v;
        logic [31:0] a;
        raw = 0;
        for (int k = 0; k < ref_nbytes(op); k++) begin
            a = addr + 32'(k);
            raw = raw + longint'(ref_ram[a[11:0]]) * (longint'(1) << (8 * k));
        end
        v = raw;
        if (op == OpLb && raw >= 128) v = raw - 256;
        if (op == OpLh && raw >= 32768) v = raw - 65536;
        return 32'(v);
    endfunction

    task automatic drive(op_e op, logic [31:0] data, logic [31:0] addr, logic [4:0] rda,
                         logic rde);
        aluop        = op;
        rd_data_in   = data;
        mem_addr     = addr;
        rd_addr_in   = rda;
        rd_enable_in = rde;
    endtask

    // One EX/MEM op, run to completion and checked against the model
    task automatic do_op(op_e op, logic [31:0] data, logic [31:0] addr, logic [4:0] rda,
                         logic rde, int gnt_delay);
        int n, busy, wrs, idle_bad, en_bad, req_bad;
        bit ld, st, mis, done;
        logic [31:0] exp_data, a;
        logic [31:0] got_data;
        logic [4:0]  got_addr;
        logic        got_en, got_mis, got_req;
        n  = ref_nbytes(op);
        ld = ref_is_load(op);
        st = (n != 0) && !ld;
        mis = ref_misaligned(op, addr);
        exp_data = ld ? ref_load(op, addr) : 32'h0;
        @(posedge clk);
        #1;
        drive(op, data, addr, rda, rde);
        if (n == 0) begin
            bus.mem_gnt = 1'b0;
            @(negedge clk);
            check_eq("pass_data", rd_data_out, data);
            check_eq("pass_addr", 32'(rd_addr_out), 32'(rda));
            check_eq("pass_en", 32'(rd_enable_out), 32'(rde));
            check_eq("pass_ctrl", {29'h0, stall_req, bus.mem_req, bus.mem_wr}, 32'h0);
            return;
        end
        bus.mem_gnt = (gnt_delay == 0);
        busy = 0; wrs = 0; idle_bad = 0; en_bad = 0; req_bad = 0; done = 0;
        got_data = 0; got_addr = 0; got_en = 0; got_mis = 0; got_req = 0;
        for (int cyc = 0; cyc < 32; cyc++) begin
            @(negedge clk);
            if (!stall_req) begin
                done     = 1;
                got_data = rd_data_out;
                got_addr = rd_addr_out;
                got_en   = rd_enable_out;
                got_mis  = misalign;
                got_req  = bus.mem_req;
                break;
            end
            busy++;
            if (bus.mem_wr) wrs++;
            if (rd_enable_out) en_bad++;
            if (!mis && !bus.mem_req) req_bad++;
            if (!bus.mem_gnt && (bus.mem_a != 0 || bus.mem_wr)) idle_bad++;
            @(posedge clk);
            #1;
            if (busy >= gnt_delay) bus.mem_gnt = 1'b1;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("busy_cycles", busy, mis ? 1 : gnt_delay + n + (ld ? 1 : 0));
        check_eq("write_strobes", wrs, (st && !mis) ? n : 0);
        check_eq("no_gnt_quiet", idle_bad, 0);
        check_eq("busy_en_low", en_bad, 0);
        check_eq("busy_req_high", req_bad, 0);
        check_eq("done_req_low", 32'(got_req), 32'd0);
        check_eq("done_misalign", 32'(got_mis), 32'(mis));
        check_eq("done_en", 32'(got_en), (ld && !mis) ? 32'(rde) : 32'd0);
        if (ld && !mis) begin
            check_eq("load_data", got_data, exp_data);
            check_eq("load_rd_addr", 32'(got_addr), 32'(rda));
        end
        if (st && !mis) begin
            for (int k = 0; k < n; k++) begin
                a = addr + 32'(k);
                ref_ram[a[11:0]] = data[8*k +: 8];
                check_eq("store_byte", 32'(ram[a[11:0]]), 32'(data[8*k +: 8]));
            end
        end
    endtask

    op_e ops [10];

    initial begin
        int bad;
        logic [31:0] r;
        ops = '{OpAdd, OpSub, OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw};
        for (int i = 0; i < 4096; i++) begin
            r = $urandom;
            ram[i]     = r[7:0];
            ref_ram[i] = r[7:0];
        end
        ram[12'h200]     = 8'h80;
        ref_ram[12'h200] = 8'h80;

        // Reset: outputs quiet even with a live passthrough op on the inputs
        rst = 1'b1;
        bus.mem_gnt = 1'b0;
        drive(OpAdd, 32'h1234, 32'h0, 5'd3, 1'b1);
        #3;
        check_eq("reset_outputs", {rd_data_out[7:0], 3'b0, rd_addr_out, 5'b0, rd_enable_out,
                                   stall_req, misalign, bus.mem_req, bus.mem_wr, bus.mem_a[7:0]},
                 32'h0);
        check_eq("reset_data", rd_data_out, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        do_op(OpAdd, 32'h1234, 32'h0, 5'd7, 1'b1, 0);
        do_op(OpSw, 32'hDEADBEEF, 32'h100, 5'd2, 1'b1, 0);
        do_op(OpLb, 32'h0, 32'h200, 5'd4, 1'b1, 0);
        do_op(OpLbu, 32'h0, 32'h200, 5'd4, 1'b1, 0);
        do_op(OpLw, 32'h0, 32'h204, 5'd9, 1'b1, 3);
        do_op(OpLw, 32'h0, 32'h102, 5'd10, 1'b1, 0);
        do_op(OpLw, 32'h0, 32'hFFFF_FFFE, 5'd11, 1'b1, 0);
        do_op(OpSh, 32'h0000_A55A, 32'hFFFF_FFFF, 5'd1, 1'b1, 1);

        // Reset in the middle of a store, after two bytes have gone out
        @(posedge clk);
        #1;
        drive(OpSw, 32'hCAFEF00D, 32'h300, 5'd6, 1'b0);
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_ctrl", {27'h0, stall_req, bus.mem_req, bus.mem_wr, rd_enable_out,
                                 misalign}, 32'h0);
        check_eq("midrst_addr", bus.mem_a, 32'h0);
        ref_ram[12'h300] = 8'h0D;
        ref_ram[12'h301] = 8'hF0;
        bus.mem_gnt = 1'b0;
        drive(OpNop, 32'h0, 32'h0, 5'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("midrst_bytes", 32'(ram[12'h300 + k]), 32'(ref_ram[12'h300 + k]));
        end
        do_op(OpXor, 32'h5555_AAAA, 32'h0, 5'd12, 1'b1, 0);

        // Randomized ops, including back-to-back memory ops and wrapped addresses
        for (int i = 0; i < 120; i++) begin
            op_e op;
            logic [31:0] addr;
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else addr = 32'($urandom_range(0, 4095));
            do_op(op, $urandom, addr, 5'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (ram[i] !== ref_ram[i]) bad++;
        end
        check_eq("ram_final", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
